fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the program counter and drives the byte address into the combinational instruction memory.
- Captures the returned 32-bit word together with its PC into the IF/ID pipeline register for decode.
- Handles stalls, branch/jump redirects, bubbles and a fetch-fault state for misaligned or out-of-range addresses.

Parameters:
- RESET_VECTOR, 32'h00000000, PC value loaded on reset.
- MEM_BYTES, 1024, size of instruction memory in bytes; legal fetch addresses are 0..MEM_BYTES-4.
- NOP_WORD, 32'h00000013, word presented on O_instr when no valid instruction is held (addi x0,x0,0).

Ports:
- I_clk  input  1  clock; all state updates on rising edge.
- I_rst  input  1  synchronous, active-high reset.
- I_stall  input  1  decode/back-end not ready; hold PC and IF/ID.
- I_redirect  input  1  taken branch/jump/trap; load I_target.
- I_target  input  32  redirect destination byte address.
- O_imem_address  output  32  byte address to instruction memory; equals PC, combinational.
- I_imem_data  input  32  instruction word returned combinationally for O_imem_address.
- O_instr  output  32  IF/ID instruction.
- O_pc  output  32  IF/ID PC of O_instr.
- O_pc_plus4  output  32  O_pc + 4 (mod 2^32), combinational from O_pc.
- O_valid  output  1  O_instr/O_pc hold a real instruction.
- O_fault  output  1  fetch fault state active.
- O_fault_addr  output  32  offending address, latched on fault entry.
- O_fetch_count  output  32  number of instructions issued (O_valid rising-edge loads); wraps at 2^32.

Behaviour:
- Reset (I_rst=1 at edge), which overrides everything:
  - PC<=RESET_VECTOR, state<=RUN, O_valid<=0, O_instr<=NOP_WORD, O_pc<=0.
  - O_fault<=0, O_fault_addr<=0, O_fetch_count<=0.
- States: RUN, FAULT. "Legal(a)" means a[1:0]==0 and a<=MEM_BYTES-4 (unsigned).
- Priority each edge in RUN: redirect > stall > advance.
- RUN, I_redirect=1 (regardless of I_stall):
  - IF/ID flushed: O_valid<=0, O_instr<=NOP_WORD, O_pc unchanged.
  - If Legal(I_target): PC<=I_target, stay RUN.
  - Else: state<=FAULT, O_fault<=1, O_fault_addr<=I_target, PC<=I_target.
  - The word currently at O_imem_address is discarded; the redirect costs exactly one bubble cycle.
- RUN, I_stall=1, I_redirect=0: PC, O_instr, O_pc, O_valid and the counter all hold.
- RUN, advance (I_stall=0, I_redirect=0):
  - O_instr<=I_imem_data, O_pc<=PC, O_valid<=1, O_fetch_count<=+1.
  - If Legal(PC+4): PC<=PC+4.
  - Else: PC<=PC+4, state<=FAULT, O_fault<=1, O_fault_addr<=PC+4. The last legal word is still issued.
  - PC arithmetic is 32-bit mod 2^32.
- First fetch after reset: in the cycle after reset deasserts, O_imem_address=RESET_VECTOR. The first advancing edge gives O_valid=1 and O_pc=RESET_VECTOR, i.e. one-cycle latency from address to IF/ID.
- FAULT state:
  - Nothing is fetched; PC frozen.
  - Each edge with I_stall=0 clears IF/ID to a bubble (O_valid<=0, O_instr<=NOP_WORD), so a held valid instruction drains to decode once before the bubble. I_stall=1 holds IF/ID.
  - Exit only via I_redirect to a Legal target: PC<=I_target, state<=RUN, O_fault<=0, O_valid<=0. O_fault_addr keeps its last value.
  - A redirect to an illegal target stays in FAULT and updates O_fault_addr.
- O_imem_address is always PC, even in FAULT. The memory is read-only and out-of-range reads are harmless, but their data is never captured.
- Reset asserted mid-stall or in FAULT returns to the reset state on that edge.

Test Plan:
- Memory bytes 0..15 = words 0x00500093, 0x00A00113, 0x002081B3, 0x00000013; reset, release, 4 advancing cycles -> O_pc 0,4,8,12 with matching O_instr, O_valid=1 from first edge, O_fetch_count=4.
- Stall held 3 cycles after O_pc=4 -> O_pc stays 4, O_instr stays 0x00A00113, O_imem_address stays 8, count unchanged. Release -> O_pc=8 next edge.
- I_redirect=1, I_target=0x40 together with I_stall=1 -> next edge O_valid=0, O_instr=0x00000013. Following edge O_pc=0x40.
- I_redirect to 0x42 -> O_fault=1, O_fault_addr=0x42, O_valid=0 thereafter. Redirect to 0x10 -> O_fault=0, O_pc=0x10 two edges later.
- Redirect to 0x3F8, run freely -> O_pc 0x3F8, 0x3FC issued valid, then O_fault=1, O_fault_addr=0x400, O_valid=0 on the next edge.
- Reset asserted while in FAULT -> next edge O_fault=0, O_fetch_count=0, O_imem_address=RESET_VECTOR, O_valid=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and loads the IF/ID register, with stall, redirect and fetch-fault handling.
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned MEM_BYTES    = 1024,
   parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_stall,
   input  logic        I_redirect,
   input  logic [31:0] I_target,
   output logic [31:0] O_imem_address,
   input  logic [31:0] I_imem_data,
   output logic [31:0] O_instr,
   output logic [31:0] O_pc,
   output logic [31:0] O_pc_plus4,
   output logic        O_valid,
   output logic        O_fault,
   output logic [31:0] O_fault_addr,
   output logic [31:0] O_fetch_count
);

   typedef enum logic {ST_RUN, ST_FAULT} state_t;

   localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

   function automatic logic legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
   endfunction

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] instr_q, instr_n;
   logic [31:0] id_pc_q, id_pc_n;
   logic        valid_q, valid_n;
   logic [31:0] fault_addr_q, fault_addr_n;
   logic [31:0] count_q, count_n;
   logic [31:0] seq_pc;

   assign seq_pc = pc + 32'd4;

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      instr_n      = instr_q;
      id_pc_n      = id_pc_q;
      valid_n      = valid_q;
      fault_addr_n = fault_addr_q;
      count_n      = count_q;
      case (state)
         ST_RUN: begin
            if (I_redirect) begin
               // The word at the current PC is dropped: one bubble per redirect.
               valid_n = 1'b0;
               instr_n = NOP_WORD;
               pc_n    = I_target;
               if (!legal(I_target)) begin
                  state_n      = ST_FAULT;
                  fault_addr_n = I_target;
               end
            end else if (!I_stall) begin
               instr_n = I_imem_data;
               id_pc_n = pc;
               valid_n = 1'b1;
               count_n = count_q + 32'd1;
               pc_n    = seq_pc;
               if (!legal(seq_pc)) begin
                  state_n      = ST_FAULT;
                  fault_addr_n = seq_pc;
               end
            end
         end
         ST_FAULT: begin
            if (I_redirect && legal(I_target)) begin
               state_n = ST_RUN;
               pc_n    = I_target;
               valid_n = 1'b0;
               instr_n = NOP_WORD;
            end else begin
               // PC stays frozen; a held instruction drains once, then bubbles.
               if (I_redirect) fault_addr_n = I_target;
               if (!I_stall) begin
                  valid_n = 1'b0;
                  instr_n = NOP_WORD;
               end
            end
         end
         default: state_n = ST_RUN;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state        <= ST_RUN;
         pc           <= RESET_VECTOR;
         instr_q      <= NOP_WORD;
         id_pc_q      <= 32'd0;
         valid_q      <= 1'b0;
         fault_addr_q <= 32'd0;
         count_q      <= 32'd0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         instr_q      <= instr_n;
         id_pc_q      <= id_pc_n;
         valid_q      <= valid_n;
         fault_addr_q <= fault_addr_n;
         count_q      <= count_n;
      end
   end

   assign O_imem_address = pc;
   assign O_instr        = instr_q;
   assign O_pc           = id_pc_q;
   assign O_pc_plus4     = id_pc_q + 32'd4;
   assign O_valid        = valid_q;
   assign O_fault        = (state == ST_FAULT);
   assign O_fault_addr   = fault_addr_q;
   assign O_fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the fetch scenarios followed by random
// stall/redirect/reset traffic, all checked against a cycle-level behavioural model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   localparam int          MEM_BYTES    = 1024;
   localparam logic [31:0] NOP_WORD     = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] imem_address;
   logic [31:0] imem_data;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        valid;
   logic        fault;
   logic [31:0] fault_addr;
   logic [31:0] fetch_count;

   logic [31:0] mem [MEM_BYTES/4];

   int checks = 0;
   int errors = 0;

   // model state: architectural view of the stage
   logic        m_init = 1'b0;
   logic [31:0] m_pc;
   logic        m_fault;
   logic [31:0] m_faddr;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_id_pc;
   logic [31:0] m_count;

   fetch_unit #(
      .RESET_VECTOR(RESET_VECTOR),
      .MEM_BYTES   (MEM_BYTES),
      .NOP_WORD    (NOP_WORD)
   ) dut (
      .I_clk         (clk),
      .I_rst         (rst),
      .I_stall       (stall),
      .I_redirect    (redirect),
      .I_target      (target),
      .O_imem_address(imem_address),
      .I_imem_data   (imem_data),
      .O_instr       (instr),
      .O_pc          (pc),
      .O_pc_plus4    (pc_plus4),
      .O_valid       (valid),
      .O_fault       (fault),
      .O_fault_addr  (fault_addr),
      .O_fetch_count (fetch_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // combinational instruction memory; out-of-range reads return junk
   assign imem_data = (imem_address < 32'(MEM_BYTES)) ? mem[imem_address[9:2]] : 32'hBAD0_BAD0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic in_range(input logic [31:0] a);
      return (a % 4 == 0) && (a < 32'(MEM_BYTES));
   endfunction

   task automatic model_edge(input logic r, input logic s, input logic rd, input logic [31:0] t);
      logic [31:0] nxt;
      if (r) begin
         m_pc = RESET_VECTOR; m_fault = 1'b0; m_faddr = 32'd0;
         m_valid = 1'b0; m_instr = NOP_WORD; m_id_pc = 32'd0; m_count = 32'd0;
         m_init = 1'b1;
      end else if (!m_fault) begin
         if (rd) begin
            m_valid = 1'b0; m_instr = NOP_WORD; m_pc = t;
            if (!in_range(t)) begin m_fault = 1'b1; m_faddr = t; end
         end else if (!s) begin
            m_instr = mem[m_pc / 4]; m_id_pc = m_pc; m_valid = 1'b1; m_count = m_count + 1;
            nxt = m_pc + 4;
            m_pc = nxt;
            if (!in_range(nxt)) begin m_fault = 1'b1; m_faddr = nxt; end
         end
      end else begin
         if (rd && in_range(t)) begin
            m_pc = t; m_fault = 1'b0; m_valid = 1'b0; m_instr = NOP_WORD;
         end else begin
            if (rd) m_faddr = t;
            if (!s) begin m_valid = 1'b0; m_instr = NOP_WORD; end
         end
      end
   endtask

   // driver: apply inputs for one cycle, then compare every output to the model
   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] t);
      rst = r; stall = s; redirect = rd; target = t;
      #1;
      if (m_init) check("imem_addr_pre", imem_address, m_pc);
      model_edge(r, s, rd, t);
      @(posedge clk);
      #1;
      check("valid",       {31'd0, valid}, {31'd0, m_valid});
      check("instr",       instr, m_instr);
      check("pc",          pc, m_id_pc);
      check("pc_plus4",    pc_plus4, m_id_pc + 32'd4);
      check("fault",       {31'd0, fault}, {31'd0, m_fault});
      check("fault_addr",  fault_addr, m_faddr);
      check("fetch_count", fetch_count, m_count);
      check("imem_addr",   imem_address, m_pc);
   endtask

   initial begin
      logic [31:0] t;
      int          sel;
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; target = 32'd0;
      for (int i = 0; i < MEM_BYTES/4; i++) mem[i] = $urandom;
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h00A0_0113;
      mem[2] = 32'h0020_81B3;
      mem[3] = 32'h0000_0013;
      @(posedge clk);
      #1;

      // reset state and straight-line fetch
      step(1, 0, 0, 0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_instr", instr, 32'h0000_0013);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0);
         check("plan_pc", pc, 32'(i * 4));
      end
      check("plan_instr3", instr, 32'h0000_0013);
      check("plan_count", fetch_count, 32'd4);

      // stall hold after O_pc=4
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0);
         check("stall_pc", pc, 32'd4);
         check("stall_instr", instr, 32'h00A0_0113);
         check("stall_addr", imem_address, 32'd8);
      end
      step(0, 0, 0, 0);
      check("release_pc", pc, 32'd8);

      // redirect wins over stall, then one bubble
      step(0, 1, 1, 32'h40);
      check("redir_bubble", {31'd0, valid}, 32'd0);
      step(0, 0, 0, 0);
      check("redir_pc", pc, 32'h40);

      // misaligned redirect -> fault, recover via legal redirect
      step(0, 0, 1, 32'h42);
      check("fault_on", {31'd0, fault}, 32'd1);
      check("fault_addr42", fault_addr, 32'h42);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 32'h10);
      check("fault_off", {31'd0, fault}, 32'd0);
      step(0, 0, 0, 0);
      check("recover_pc", pc, 32'h10);

      // run off the end of memory
      step(0, 0, 1, 32'h3F8);
      step(0, 0, 0, 0);
      check("end_pc0", pc, 32'h3F8);
      step(0, 0, 0, 0);
      check("end_pc1", pc, 32'h3FC);
      check("end_valid", {31'd0, valid}, 32'd1);
      check("end_faddr", fault_addr, 32'h400);
      step(0, 0, 0, 0);
      check("end_bubble", {31'd0, valid}, 32'd0);

      // reset while in FAULT
      step(1, 0, 0, 0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      check("rst_count", fetch_count, 32'd0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         sel = $urandom_range(0, 99);
         case ($urandom_range(0, 4))
            0:       t = 32'($urandom_range(0, MEM_BYTES/4 - 1)) << 2;
            1:       t = 32'(MEM_BYTES) - 32'(4 * $urandom_range(1, 3));
            2:       t = (32'($urandom_range(0, MEM_BYTES/4 - 1)) << 2) | 32'($urandom_range(1, 3));
            3:       t = 32'(MEM_BYTES) + 32'($urandom_range(0, 64));
            default: t = $urandom;
         endcase
         if (sel < 2)       step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
         else if (sel < 14) step(0, 1'($urandom_range(0, 1)), 1, t);
         else if (sel < 40) step(0, 1, 0, t);
         else               step(0, 0, 0, t);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
